opl3_detect_assist: RTL and testbench
=====================================

# opl3_detect_assist

Two-timer OPL3 detection assist for the OPL3 core's host register interface. The block watches host writes to the timer preset registers (0x02, 0x03) and the timer control register (0x04, bank 0). It then counts status-port reads after a qualifying timer start, and forces a per-timer overflow once a configurable read count is reached. This lets software that busy-waits with status reads pass OPL detection on fast hosts. It sits beside the timer block, shares the core clock, and drives each timer's force-overflow input directly.

## Interface
- READ_THRESHOLD, 50: status reads after a qualifying start before forcing overflow; must be ≥1.
- TIMER1_MATCH, 8'hFF: preset value of reg 0x02 required to arm timer 1.
- TIMER2_MATCH, 8'hFF: preset value of reg 0x03 required to arm timer 2.
- REG_FILE_DATA_WIDTH, 8: host data bus width.

- clk  in  1  core clock; the host bus is already synchronous to it.
- ic_n  in  1  reset, asynchronous, active-low.
- cs_n, rd_n, wr_n  in  1 each  host strobes, active-low.
- address  in  2  bit0 is 0 for address/status and 1 for data; bit1 is the bank.
- din  in  REG_FILE_DATA_WIDTH  host write data.
- enable  in  1  runtime enable; low holds both timers IDLE.
- force_timer_overflow  out  2  bit0 is timer 1 and bit1 is timer 2; level output, registered.
- armed  out  2  per-timer state ≠ IDLE; registered.

## Operation
- **Pin stage.** cs_n, rd_n, wr_n, address and din are registered once into the p1 stage and once more for edge detection into the p2 stage.
  - wr = !cs_n && !wr_n, taken at p1.
  - rd = !cs_n && !rd_n, taken at p1.
  - Write edge = wr_p1 && !wr_p2. Read edge = rd_p1 && !rd_p2.
- **Write decode.**
  - On a write edge with address[0]=0: latch bank = address[1] and reg address = din.
  - On a write edge with address[0]=1: raise a one-cycle reg-write event (registered) carrying the latched bank/address and din.
- **Shadows.** A bank-0 event writes shadow t1 (reg 0x02) or shadow t2 (reg 0x03). Both shadows reset to 0.
- **Counted reads.** Only read edges with address[0]=0 (status reads) are counted. Reads of the data port are ignored.
- **Per-timer FSM:** states IDLE, ARMED, FIRED. For timer n, the start bit is bit0 (T1) or bit1 (T2), and the mask bit is bit6 (T1) or bit5 (T2).
  - **Arm condition** (reg 0x04 bank-0 event, all of):
    - data[7]=0;
    - start bit = 1;
    - mask bit = 0;
    - shadow_n == TIMERn_MATCH;
    - enable = 1.
  - **Cancel condition** (reg 0x04 bank-0 event, any of):
    - data[7]=1;
    - start bit = 0;
    - mask bit = 1.
  - **Preset write:** a write to timer n's own preset register (bank 0) also cancels timer n.
  - **Transitions:**
    - any state, arm condition → ARMED, with counter cleared and force cleared; re-arming from ARMED or FIRED restarts the count;
    - any state, cancel condition → IDLE;
    - any state, preset write → IDLE;
    - ARMED, counter == READ_THRESHOLD → FIRED;
    - FIRED: force_timer_overflow[n]=1, held until cancel, re-arm, enable low or reset.
- **Non-cancelling writes.** Writes to registers other than 0x02, 0x03 and 0x04 in bank 0, and all bank-1 writes, do not affect either FSM. Interleaved register writes are tolerated.
- **Counter.** Per-timer counter, $clog2(READ_THRESHOLD+1) bits. It increments only in ARMED and saturates at READ_THRESHOLD.
- **Simultaneous events.** If a reg-write event and a read edge occur in the same cycle, the write action is taken and the read is not counted.
- **Enable low.** Both FSMs go to IDLE, counters clear, and forces drop on the next edge.
- **Reset (ic_n low, any time, including mid-count).** All registers clear immediately: states IDLE, counters 0, shadows 0, force 0, armed 0, and pin stages idle (strobes inactive).

## Timing
- Reset values: force_timer_overflow=2'b00, armed=2'b00.
- **Write path.** Pins sampled at edge k → p1 at k → reg-write event at k+1 → state/armed updates at k+2.
- **Read path.** Read pins sampled at edge k → counter increments at k+1.
- **Force latency.** When the counter reaches READ_THRESHOLD at edge j, FIRED and force=1 take effect at edge j+1.
- **Cancel/re-arm.** force drops at the same edge as a cancel or re-arm state update.
- **Multi-cycle strobes.** A strobe held low for many cycles produces exactly one edge.
- **Cross-domain use.** No internal synchronizer. A consumer in another clock domain must synchronize force_timer_overflow itself.

## Test plan
- **Detection, timer 1.** Write 0x02=0xFF, 0x04=0x80, then 0x04=0x21 → armed=01. After 49 status reads force=00; the 50th read gives force[0]=1 two edges after its pins were sampled. Then write 0x04=0x60 → force=00, armed=00.
- **Preset mismatch.** 0x02=0xFE, then 0x04=0x01, then 100 reads → armed and force stay 00.
- **Timer 2 independence.** 0x03=0xFF, then 0x04=0x42 → armed=10. After 50 reads force=10. Data-port reads and a write to reg 0xB0 do not change count or state.
- **Re-arm and simultaneity.** Arm T1, do 30 reads, then rewrite 0x04=0x01 → counter restarts, so force needs 50 further reads. A read edge coincident with the event is not counted.
- **Reset and enable.** With T1 in FIRED: pulse ic_n low mid-cycle → force=00 asynchronously and all state clear. Re-arm with enable=0 → armed stays 00.

Source files
------------

// File: rtl/opl3_detect_assist.sv
// OPL3 detection assist: watches host writes to the timer preset/control
// registers and forces a timer overflow after a fixed number of status reads,
// so busy-wait detection loops succeed on hosts that poll faster than the
// real timers tick.
`timescale 1ns/1ps
module opl3_detect_assist #(
  parameter int         READ_THRESHOLD      = 50,
  parameter logic [7:0] TIMER1_MATCH        = 8'hFF,
  parameter logic [7:0] TIMER2_MATCH        = 8'hFF,
  parameter int         REG_FILE_DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           ic_n,
  input  logic                           cs_n,
  input  logic                           rd_n,
  input  logic                           wr_n,
  input  logic [1:0]                     address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] din,
  input  logic                           enable,
  output logic [1:0]                     force_timer_overflow,
  output logic [1:0]                     armed
);

  localparam int DW = REG_FILE_DATA_WIDTH;
  localparam int CW = $clog2(READ_THRESHOLD + 1);

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

  // p1 pin stage, p2 strobe history, latched register pointer, write event
  logic          cs_n_q, rd_n_q, wr_n_q;
  logic [1:0]    addr_q;
  logic [DW-1:0] din_q;
  logic          wr_p2_q, rd_p2_q;
  logic          bank_q, bank_d;
  logic [DW-1:0] reg_addr_q, reg_addr_d;
  logic          ev_q, ev_d;
  logic          ev_bank_q, ev_bank_d;
  logic [DW-1:0] ev_addr_q, ev_addr_d;
  logic [DW-1:0] ev_data_q, ev_data_d;

  logic wr_p1, rd_p1, wr_edge, rd_edge, status_rd;
  logic ev_bank0, wr_ctrl;

  assign wr_p1     = !cs_n_q && !wr_n_q;
  assign rd_p1     = !cs_n_q && !rd_n_q;
  assign wr_edge   = wr_p1 && !wr_p2_q;
  assign rd_edge   = rd_p1 && !rd_p2_q;
  // Only status-port reads count, and never in a cycle that carries a write event
  assign status_rd = rd_edge && !addr_q[0] && !ev_q;
  assign ev_bank0  = ev_q && !ev_bank_q;
  assign wr_ctrl   = ev_bank0 && (ev_addr_q == DW'(8'h04));

  // Address-phase writes latch the pointer; data-phase writes raise an event
  always_comb begin
    bank_d     = bank_q;
    reg_addr_d = reg_addr_q;
    if (wr_edge && !addr_q[0]) begin
      bank_d     = addr_q[1];
      reg_addr_d = din_q;
    end
    ev_d      = wr_edge && addr_q[0];
    ev_bank_d = bank_q;
    ev_addr_d = reg_addr_q;
    ev_data_d = din_q;
  end

  // Host pin pipeline and write decode registers
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      wr_p2_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      bank_q     <= 1'b0;
      reg_addr_q <= '0;
      ev_q       <= 1'b0;
      ev_bank_q  <= 1'b0;
      ev_addr_q  <= '0;
      ev_data_q  <= '0;
    end else begin
      cs_n_q     <= cs_n;
      rd_n_q     <= rd_n;
      wr_n_q     <= wr_n;
      addr_q     <= address;
      din_q      <= din;
      wr_p2_q    <= wr_p1;
      rd_p2_q    <= rd_p1;
      bank_q     <= bank_d;
      reg_addr_q <= reg_addr_d;
      ev_q       <= ev_d;
      ev_bank_q  <= ev_bank_d;
      ev_addr_q  <= ev_addr_d;
      ev_data_q  <= ev_data_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_timer
      // Timer 1 uses start bit0 / mask bit6, timer 2 start bit1 / mask bit5
      localparam logic [7:0] MATCH = (gi == 0) ? TIMER1_MATCH : TIMER2_MATCH;

      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [DW-1:0] shadow_q, shadow_d;
      logic          force_q, force_d;
      logic          armed_q, armed_d;
      logic          preset_wr, start_bit, mask_bit, arm, cancel;

      assign preset_wr = ev_bank0 && (ev_addr_q == DW'(gi + 2));
      assign start_bit = ev_data_q[gi];
      assign mask_bit  = ev_data_q[6-gi];
      assign arm       = wr_ctrl && !ev_data_q[7] && start_bit && !mask_bit &&
                         (shadow_q == DW'(MATCH)) && enable;
      assign cancel    = wr_ctrl && (ev_data_q[7] || !start_bit || mask_bit);

      // Next-state: enable low wins, then arm, then cancel/preset, then counting
      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = preset_wr ? ev_data_q : shadow_q;
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else if (cancel || preset_wr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (state_q == ARMED) begin
          if (cnt_q == CW'(READ_THRESHOLD)) begin
            state_d = FIRED;
          end else if (status_rd) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        force_d = (state_d == FIRED);
        armed_d = (state_d != IDLE);
      end

      // Per-timer state, counter, shadow and registered outputs
      always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          shadow_q <= '0;
          force_q  <= 1'b0;
          armed_q  <= 1'b0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          shadow_q <= shadow_d;
          force_q  <= force_d;
          armed_q  <= armed_d;
        end
      end

      assign force_timer_overflow[gi] = force_q;
      assign armed[gi]                = armed_q;
    end
  endgenerate

endmodule

// File: tb/tb_opl3_detect_assist.sv
// Bench for opl3_detect_assist: drives host register writes and status reads,
// queues expected {force, armed} values and compares them as outputs settle.
`timescale 1ns/1ps
module tb_opl3_detect_assist;

  logic       clk = 1'b0;
  logic       ic_n;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] address;
  logic [7:0] din;
  logic       enable;
  logic [1:0] force_timer_overflow;
  logic [1:0] armed;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  opl3_detect_assist dut (
    .clk                  (clk),
    .ic_n                 (ic_n),
    .cs_n                 (cs_n),
    .rd_n                 (rd_n),
    .wr_n                 (wr_n),
    .address              (address),
    .din                  (din),
    .enable               (enable),
    .force_timer_overflow (force_timer_overflow),
    .armed                (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %-20s force/armed got=%b required=%b", tag, got, exp);
    end else begin
      $display("ok   %-20s force/armed=%b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_expect(input string tag, input logic [1:0] f, input logic [1:0] a);
    sb_item_t it;
    it.tag = tag;
    it.exp = {f, a};
    sb_q.push_back(it);
  endtask

  task automatic sb_compare();
    sb_item_t it;
    if (sb_q.size() == 0) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL sb_empty got=%0d entries required>=1", sb_q.size());
    end else begin
      it = sb_q.pop_front();
      check(it.tag, {force_timer_overflow, armed}, it.exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs_n = 1'b0; wr_n = 1'b0; address = a; din = d;
    tick(); tick();
    cs_n = 1'b1; wr_n = 1'b1;
    tick(); tick();
  endtask

  task automatic reg_write(input logic bank, input logic [7:0] r, input logic [7:0] v);
    bus_write({bank, 1'b0}, r);
    bus_write({bank, 1'b1}, v);
  endtask

  // Data write immediately followed by a status read whose edge lands in
  // the same cycle as the resulting register-write event
  task automatic reg_write_with_read(input logic bank, input logic [7:0] r, input logic [7:0] v);
    bus_write({bank, 1'b0}, r);
    cs_n = 1'b0; wr_n = 1'b0; address = {bank, 1'b1}; din = v;
    tick();
    wr_n = 1'b1; rd_n = 1'b0; address = 2'b00;
    tick();
    rd_n = 1'b1; cs_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic host_read(input logic a0);
    cs_n = 1'b0; rd_n = 1'b0; address = {1'b0, a0};
    tick();
    cs_n = 1'b1; rd_n = 1'b1;
    tick();
  endtask

  task automatic status_reads(input int n);
    for (int i = 0; i < n; i++) host_read(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ic_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    address = 2'b00; din = 8'h00; enable = 1'b1;
    repeat (3) tick();
    sb_expect("reset", 2'b00, 2'b00);
    sb_compare();
    ic_n = 1'b1;
    tick();

    // Timer 1 detection
    reg_write(1'b0, 8'h02, 8'hFF);
    reg_write(1'b0, 8'h04, 8'h80);
    sb_expect("t1_arm", 2'b00, 2'b01);
    reg_write(1'b0, 8'h04, 8'h21);
    sb_compare();
    status_reads(49);
    tick();
    sb_expect("t1_49_reads", 2'b00, 2'b01);
    sb_compare();
    sb_expect("t1_50th_edge_k", 2'b00, 2'b01);
    sb_expect("t1_50th_edge_k1", 2'b00, 2'b01);
    sb_expect("t1_50th_edge_k2", 2'b01, 2'b01);
    cs_n = 1'b0; rd_n = 1'b0; address = 2'b00;
    tick();
    cs_n = 1'b1; rd_n = 1'b1;
    sb_compare();
    tick();
    sb_compare();
    tick();
    sb_compare();
    sb_expect("t1_cancel_mask", 2'b00, 2'b00);
    reg_write(1'b0, 8'h04, 8'h60);
    sb_compare();

    // Preset mismatch never arms
    reg_write(1'b0, 8'h02, 8'hFE);
    sb_expect("mismatch_ctrl", 2'b00, 2'b00);
    reg_write(1'b0, 8'h04, 8'h01);
    sb_compare();
    sb_expect("mismatch_100_reads", 2'b00, 2'b00);
    status_reads(100);
    tick(); tick();
    sb_compare();

    // Timer 2 independence; data reads and unrelated writes are ignored
    reg_write(1'b0, 8'h03, 8'hFF);
    sb_expect("t2_arm", 2'b00, 2'b10);
    reg_write(1'b0, 8'h04, 8'h42);
    sb_compare();
    sb_expect("t2_49_plus_noise", 2'b00, 2'b10);
    status_reads(49);
    for (int i = 0; i < 3; i++) host_read(1'b1);
    reg_write(1'b0, 8'hB0, 8'h12);
    reg_write(1'b1, 8'h04, 8'h01);
    tick();
    sb_compare();
    sb_expect("t2_50th_fire", 2'b10, 2'b10);
    host_read(1'b0);
    tick();
    sb_compare();

    // Re-arm restarts the count; coincident reads are not counted
    reg_write(1'b0, 8'h02, 8'hFF);
    sb_expect("t1_rearm_first", 2'b00, 2'b01);
    reg_write(1'b0, 8'h04, 8'h01);
    sb_compare();
    status_reads(30);
    sb_expect("t1_rearm_coincident", 2'b00, 2'b01);
    reg_write_with_read(1'b0, 8'h04, 8'h01);
    sb_compare();
    status_reads(49);
    sb_expect("t1_rearm_49_reads", 2'b00, 2'b01);
    reg_write_with_read(1'b0, 8'hB0, 8'h00);
    tick();
    sb_compare();
    sb_expect("t1_rearm_50th_fire", 2'b01, 2'b01);
    host_read(1'b0);
    tick();
    sb_compare();

    // Asynchronous reset mid-cycle while fired
    #2;
    ic_n = 1'b0;
    #1;
    sb_expect("async_reset", 2'b00, 2'b00);
    sb_compare();
    tick();
    ic_n = 1'b1;
    tick();
    sb_expect("post_reset_shadow0", 2'b00, 2'b00);
    reg_write(1'b0, 8'h04, 8'h01);
    sb_compare();

    // Enable gating
    enable = 1'b0;
    reg_write(1'b0, 8'h02, 8'hFF);
    sb_expect("arm_enable_low", 2'b00, 2'b00);
    reg_write(1'b0, 8'h04, 8'h01);
    sb_compare();
    enable = 1'b1;
    sb_expect("arm_enable_high", 2'b00, 2'b01);
    reg_write(1'b0, 8'h04, 8'h01);
    sb_compare();
    sb_expect("fire_enable_high", 2'b01, 2'b01);
    status_reads(50);
    tick();
    sb_compare();
    sb_expect("enable_drop", 2'b00, 2'b00);
    enable = 1'b0;
    tick();
    sb_compare();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
